display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Time-multiplexed scan driver for the 4-digit HH:MM seven-segment display of the alarm clock.
- Sits between the timekeeping/alarm-set logic and the BCD-to-seven-segment display decoder.
- Drives one BCD digit at a time to the decoder and the matching active-low digit anode.
- Provides a frame-coherent digit snapshot, digit blinking for set mode, leading-zero blanking of hour tens, and a flashing colon.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; legal range >= 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period; legal range >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  1 = scan running; 0 = display dark and counters frozen.
- digits_in  input  16  BCD time. [15:12] hour tens, [11:8] hour ones, [7:4] minute tens, [3:0] minute ones.
- blink_mask  input  4  per-digit blink enable. Bit i maps to slot i (slot 0 = minute ones).
- lz_blank  input  1  1 = blank slot 3 when its snapshot digit is 0.
- bcd_out  output  4  BCD digit sent to the decoder.
- an_n  output  4  active-low anode select. One-hot-low when lit; 4'b1111 when dark.
- dp_n  output  1  active-low colon/decimal point.
- slot  output  2  index of the slot currently driven.

Behaviour:
- Reset state (asynchronous): prescaler=0, slot=3, snapshot=16'h0000, blink counter=0, blink_phase=1 (visible), bcd_out=4'd0, an_n=4'b1111, dp_n=1.
- Prescaler, when enable=1:
  - counts 0..SCAN_DIV-1 and wraps to 0;
  - a scan tick is the cycle in which the prescaler equals SCAN_DIV-1.
- On each scan tick:
  - slot advances 0->1->2->3->0;
  - all outputs (bcd_out, an_n, dp_n) are registered and update on the same edge for the new slot.
- Frame snapshot:
  - on a tick that wraps slot 3->0, snapshot <= digits_in;
  - slot 0 on that edge uses the incoming digits_in value directly;
  - digits_in changes mid-frame never appear until the next frame, so there is no tearing;
  - first frame after reset: the first tick wraps 3->0, so the display is dark for SCAN_DIV cycles, then slot 0 lights.
- bcd_out = snapshot nibble for the slot.
  - Values above 9 pass through unchanged; the decoder renders them as a dash.
- Slot visible unless any of the following holds:
  - blink_mask[slot]=1 and blink_phase=0;
  - slot=3 and lz_blank=1 and the snapshot nibble is 4'd0;
  - enable=0.
- Visible slot: an_n = ~(4'b0001 << slot). Blanked slot: an_n = 4'b1111; bcd_out still updates.
- Blink counter, when enable=1:
  - counts 0..BLINK_DIV-1;
  - blink_phase toggles at the terminal count.
- Blink restart: when blink_mask goes from 4'b0000 to nonzero (edge-detected against a registered copy), the blink counter clears and blink_phase is forced to 1 on the next edge. This takes priority over a coincident toggle.
- dp_n = 0 only when slot=2 is driven, enable=1 and blink_phase=1. The colon therefore flashes at the blink rate.
- enable=0:
  - an_n <= 4'b1111 and dp_n <= 1 on the next edge;
  - prescaler, slot, blink counter and snapshot hold;
  - on return to 1, counting resumes from the held values.
- Reset asserted mid-frame forces the reset state immediately, independent of clk. The first lit output after release follows the first-frame rule above.
- Simultaneous events: a scan tick, a blink toggle and a blink restart may all fall on one edge.
  - Each register updates independently.
  - Blanking for that edge uses the updated blink_phase.

Test Plan (SCAN_DIV=4, BLINK_DIV=16):
- Reset, enable=1, digits_in=16'h1234, blink_mask=0, lz_blank=0 ->
  - an_n stays 4'b1111 for 4 cycles;
  - then slots 0,1,2,3 show bcd_out 4,3,2,1 with an_n 1110,1101,1011,0111, each held 4 cycles;
  - then the sequence repeats.
- Change digits_in to 16'h0959 while slot 1 is driven -> slots 2,3 still show 2,1; the next frame shows 9,5,9,0.
- digits_in=16'h0959, lz_blank=1 -> slot 3 an_n=4'b1111, bcd_out=0. With lz_blank=0, slot 3 lit with an_n=0111.
- blink_mask=4'b1100 (from 0) ->
  - phase forced visible;
  - slots 2,3 lit for 16 cycles, dark for 16, lit again;
  - slots 0,1 unaffected;
  - dp_n low in slot 2 only during the visible phase.
- enable dropped for 10 cycles during slot 1 -> an_n=1111 and dp_n=1 next edge; counters frozen; on re-enable slot 1 finishes its remaining cycles.
- Assert reset asynchronously between clock edges mid-frame -> outputs take reset values immediately; normal sequence restarts with slot 0 after SCAN_DIV cycles.

Source files
------------

// File: rtl/display_scan_mux.sv
// Four-digit HH:MM scan driver: one BCD digit and one active-low anode per slot,
// with frame-coherent snapshot, set-mode blinking, hour-tens blanking and flashing colon.
module display_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic        lz_blank,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an_n,
  output logic        dp_n,
  output logic [1:0]  slot
);

  localparam int PW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] prescaler, prescaler_next;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          blink_phase, phase_next;
  logic [15:0]   snapshot, snapshot_next;
  logic [3:0]    mask_q;
  logic          frame_live, live_next;
  logic [1:0]    slot_next;
  logic          scan_tick, wrap, restart, blink_term;
  logic [3:0]    nibble;
  logic          blanked;

  always_comb begin
    scan_tick      = enable && (prescaler == SCAN_LAST);
    wrap           = scan_tick && (slot == 2'd3);
    prescaler_next = prescaler;
    if (enable)
      prescaler_next = scan_tick ? '0 : prescaler + PW'(1);
    slot_next      = scan_tick ? slot + 2'd1 : slot;
    snapshot_next  = wrap ? digits_in : snapshot;
    // Outputs stay dark until the first frame has been captured after reset.
    live_next      = frame_live | wrap;

    restart        = (mask_q == 4'd0) && (blink_mask != 4'd0);
    blink_term     = enable && (blink_cnt == BLINK_LAST);
    blink_cnt_next = blink_cnt;
    if (enable)
      blink_cnt_next = blink_term ? '0 : blink_cnt + BW'(1);
    phase_next     = blink_term ? ~blink_phase : blink_phase;
    if (restart) begin
      blink_cnt_next = '0;
      phase_next     = 1'b1;
    end

    case (slot_next)
      2'd0:    nibble = snapshot_next[3:0];
      2'd1:    nibble = snapshot_next[7:4];
      2'd2:    nibble = snapshot_next[11:8];
      default: nibble = snapshot_next[15:12];
    endcase

    blanked = (blink_mask[slot_next] && !phase_next) ||
              ((slot_next == 2'd3) && lz_blank && (nibble == 4'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      slot        <= 2'd3;
      snapshot    <= 16'h0000;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      mask_q      <= 4'd0;
      frame_live  <= 1'b0;
    end else begin
      prescaler   <= prescaler_next;
      slot        <= slot_next;
      snapshot    <= snapshot_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= phase_next;
      mask_q      <= blink_mask;
      frame_live  <= live_next;
    end
  end

  // Outputs are recomputed every enabled edge from the post-edge state so blink
  // and blanking changes show up mid-slot, and slot changes land on the tick edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_out <= 4'd0;
      an_n    <= 4'b1111;
      dp_n    <= 1'b1;
    end else if (!enable) begin
      an_n <= 4'b1111;
      dp_n <= 1'b1;
    end else if (live_next) begin
      bcd_out <= nibble;
      an_n    <= blanked ? 4'b1111 : ~(4'b0001 << slot_next);
      dp_n    <= !((slot_next == 2'd2) && phase_next);
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed table-driven bench for display_scan_mux with SCAN_DIV=4, BLINK_DIV=16;
// edge numbers count rising edges since reset release.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic [1:0]  slot;

  int checks = 0;
  int passes = 0;
  int edge_count = 0;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  mask;
    logic        lz;
    logic        en;
    int          edge_n;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  slt;
  } vec_t;

  vec_t vecs[$];

  display_scan_mux #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .digits_in(digits_in),
    .blink_mask(blink_mask),
    .lz_blank(lz_blank),
    .bcd_out(bcd_out),
    .an_n(an_n),
    .dp_n(dp_n),
    .slot(slot)
  );

  always #5 clk = ~clk;

  function automatic void addVec(input logic [15:0] d, input logic [3:0] m, input logic lz,
                                 input logic en, input int e, input logic [3:0] b,
                                 input logic [3:0] a, input logic dp, input logic [1:0] s);
    vec_t v;
    v.digits = d; v.mask = m; v.lz = lz; v.en = en; v.edge_n = e;
    v.bcd = b; v.an = a; v.dp = dp; v.slt = s;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m, input logic lz,
                               input logic en);
    digits_in  = d;
    blink_mask = m;
    lz_blank   = lz;
    enable     = en;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] b, input logic [3:0] a,
                             input logic dp, input logic [1:0] s);
    checks++;
    if (bcd_out === b && an_n === a && dp_n === dp && slot === s)
      passes++;
    else
      $display("[TB] FAIL %s: got bcd=%h an_n=%b dp_n=%b slot=%0d, expected bcd=%h an_n=%b dp_n=%b slot=%0d",
               name, bcd_out, an_n, dp_n, slot, b, a, dp, s);
  endtask

  initial begin
    // Normal scan of 12:34, first frame dark for 4 cycles
    addVec(16'h1234, 4'h0, 0, 1,   1, 4'h0, 4'b1111, 1, 2'd3);
    addVec(16'h1234, 4'h0, 0, 1,   3, 4'h0, 4'b1111, 1, 2'd3);
    addVec(16'h1234, 4'h0, 0, 1,   4, 4'h4, 4'b1110, 1, 2'd0);
    addVec(16'h1234, 4'h0, 0, 1,   7, 4'h4, 4'b1110, 1, 2'd0);
    addVec(16'h1234, 4'h0, 0, 1,   8, 4'h3, 4'b1101, 1, 2'd1);
    addVec(16'h1234, 4'h0, 0, 1,  12, 4'h2, 4'b1011, 0, 2'd2);
    addVec(16'h1234, 4'h0, 0, 1,  15, 4'h2, 4'b1011, 0, 2'd2);
    addVec(16'h1234, 4'h0, 0, 1,  16, 4'h1, 4'b0111, 1, 2'd3);
    addVec(16'h1234, 4'h0, 0, 1,  20, 4'h4, 4'b1110, 1, 2'd0);
    addVec(16'h1234, 4'h0, 0, 1,  24, 4'h3, 4'b1101, 1, 2'd1);
    // Mid-frame change to 09:59 must wait for the next frame
    addVec(16'h0959, 4'h0, 0, 1,  28, 4'h2, 4'b1011, 1, 2'd2);
    addVec(16'h0959, 4'h0, 0, 1,  32, 4'h1, 4'b0111, 1, 2'd3);
    addVec(16'h0959, 4'h0, 0, 1,  36, 4'h9, 4'b1110, 1, 2'd0);
    addVec(16'h0959, 4'h0, 0, 1,  40, 4'h5, 4'b1101, 1, 2'd1);
    addVec(16'h0959, 4'h0, 0, 1,  44, 4'h9, 4'b1011, 0, 2'd2);
    addVec(16'h0959, 4'h0, 0, 1,  48, 4'h0, 4'b0111, 1, 2'd3);
    // Leading-zero blanking of hour tens
    addVec(16'h0959, 4'h0, 1, 1,  49, 4'h0, 4'b1111, 1, 2'd3);
    addVec(16'h0959, 4'h0, 0, 1,  51, 4'h0, 4'b0111, 1, 2'd3);
    addVec(16'h0959, 4'h0, 0, 1,  52, 4'h9, 4'b1110, 1, 2'd0);
    // Blink restart at edge 53, toggles at 69, 85, 101
    addVec(16'h0959, 4'hC, 0, 1,  53, 4'h9, 4'b1110, 1, 2'd0);
    addVec(16'h0959, 4'hC, 0, 1,  60, 4'h9, 4'b1011, 0, 2'd2);
    addVec(16'h0959, 4'hC, 0, 1,  64, 4'h0, 4'b0111, 1, 2'd3);
    addVec(16'h0959, 4'hC, 0, 1,  68, 4'h9, 4'b1110, 1, 2'd0);
    addVec(16'h0959, 4'hC, 0, 1,  69, 4'h9, 4'b1110, 1, 2'd0);
    addVec(16'h0959, 4'hC, 0, 1,  76, 4'h9, 4'b1111, 1, 2'd2);
    addVec(16'h0959, 4'hC, 0, 1,  80, 4'h0, 4'b1111, 1, 2'd3);
    addVec(16'h0959, 4'hC, 0, 1,  92, 4'h9, 4'b1011, 0, 2'd2);
    addVec(16'h0959, 4'hC, 0, 1,  96, 4'h0, 4'b0111, 1, 2'd3);
    // Enable dropped for edges 106..115 during slot 1; blink toggle moves 117 -> 127
    addVec(16'h0959, 4'h0, 0, 1, 105, 4'h5, 4'b1101, 1, 2'd1);
    addVec(16'h0959, 4'h0, 0, 0, 106, 4'h5, 4'b1111, 1, 2'd1);
    addVec(16'h0959, 4'h0, 0, 0, 115, 4'h5, 4'b1111, 1, 2'd1);
    addVec(16'h0959, 4'h0, 0, 1, 116, 4'h5, 4'b1101, 1, 2'd1);
    addVec(16'h0959, 4'h0, 0, 1, 117, 4'h5, 4'b1101, 1, 2'd1);
    addVec(16'h0959, 4'h0, 0, 1, 118, 4'h9, 4'b1011, 1, 2'd2);
    addVec(16'h0959, 4'h0, 0, 1, 122, 4'h0, 4'b0111, 1, 2'd3);
    addVec(16'h0959, 4'h0, 0, 1, 134, 4'h9, 4'b1011, 0, 2'd2);

    reset = 1'b1;
    applyStimulus(16'h1234, 4'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_state", 4'h0, 4'b1111, 1'b1, 2'd3);
    @(negedge clk);
    reset = 1'b0;
    edge_count = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].digits, vecs[i].mask, vecs[i].lz, vecs[i].en);
      while (edge_count < vecs[i].edge_n) begin
        @(posedge clk);
        edge_count++;
      end
      #1 checkOutput($sformatf("vec%0d_edge%0d", i, vecs[i].edge_n),
                     vecs[i].bcd, vecs[i].an, vecs[i].dp, vecs[i].slt);
    end

    // Asynchronous reset between edges while slot 2 and the colon are lit
    #3 reset = 1'b1;
    #1 checkOutput("async_reset_immediate", 4'h0, 4'b1111, 1'b1, 2'd3);
    @(posedge clk);
    #1 checkOutput("reset_held_over_edge", 4'h0, 4'b1111, 1'b1, 2'd3);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("post_reset_dark", 4'h0, 4'b1111, 1'b1, 2'd3);
    @(posedge clk);
    #1 checkOutput("post_reset_slot0", 4'h9, 4'b1110, 1'b1, 2'd0);
    repeat (4) @(posedge clk);
    #1 checkOutput("post_reset_slot1", 4'h5, 4'b1101, 1'b1, 2'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
